// File: rtl/mem_responder_mips_pkg.sv
// Shared types and default sizing for the MIPS data-memory responder.
// No logic: state encoding, width defaults and index-width helper only.
// Imported by the interface, the storage array and the responder top.
package mips_pkg;

    localparam int DEF_MEM_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_MEM_DEPTH  = 64;
    localparam int DEF_RD_LATENCY = 2;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_responder_mips_if.sv
// Request/response bundle between the core datapath and the memory responder.
// Latency: none (wires only).
// Backpressure: the core holds req_valid until req_ready; responses cannot be stalled.
interface mem_responder_mips_if
    import mips_pkg::*;
#(
    parameter int mem_width  = DEF_MEM_WIDTH,
    parameter int addr_width = DEF_ADDR_WIDTH
) ();

    logic                  req_valid;
    logic                  req_wr;
    logic [addr_width-1:0] req_addr;
    logic [mem_width-1:0]  req_wdata;
    logic                  req_ready;
    logic                  rsp_valid;
    logic [mem_width-1:0]  rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_responder_mips_array.sv
// Word storage: synchronous write, combinational read, async clear to zero.
// Latency: write visible the cycle after the write edge; read is same-cycle.
// Backpressure: none, one write per cycle always accepted.
module mem_array_mips
    import mips_pkg::*;
#(
    parameter int width = DEF_MEM_WIDTH,
    parameter int depth = DEF_MEM_DEPTH,
    parameter int idx_w = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [idx_w-1:0] waddr_i,
    input  logic [width-1:0] wdata_i,
    input  logic [idx_w-1:0] raddr_i,
    output logic [width-1:0] rdata_o
);

    logic [width-1:0] mem_q [depth];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder_mips.sv
// Single-outstanding data-memory responder for a MIPS core; MEM_ERR_CHECK_EN adds fault checks.
// Latency: response strobe exactly rd_latency cycles after accept; stores commit leaving RESP.
// Backpressure: req_ready only in IDLE (no queueing); responses are never stalled.
module mem_responder_mips
    import mips_pkg::*;
#(
    parameter int mem_width  = DEF_MEM_WIDTH,
    parameter int addr_width = DEF_ADDR_WIDTH,
    parameter int mem_depth  = DEF_MEM_DEPTH,
    parameter int rd_latency = DEF_RD_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_responder_mips_if.slave  bus
);

    localparam int IDX_W = idx_width(mem_depth);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [mem_width-1:0]  wdata_q, wdata_d;

    logic                  accept;
    logic                  fault;
    logic                  mem_we;
    logic [addr_width-1:0] word;
    logic [IDX_W-1:0]      idx;
    logic [mem_width-1:0]  rd_data;

    // Word index always wraps; in the checked build out-of-range words are faulted before use.
    assign word = addr_q >> 2;
    assign idx  = IDX_W'(word % addr_width'(mem_depth));

`ifdef MEM_ERR_CHECK_EN
    assign fault = (addr_q[1:0] != 2'b00) || (word >= addr_width'(mem_depth));
`else
    assign fault = 1'b0;
`endif

    assign bus.req_ready = (state_q == IDLE);
    assign accept        = bus.req_valid && bus.req_ready;
    assign mem_we        = (state_q == RESP) && wr_q && !fault;

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = ((state_q == RESP) && !wr_q && !fault) ? rd_data : '0;
    assign bus.rsp_err   = (state_q == RESP) && fault;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    wr_d    = bus.req_wr;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (rd_latency == 1) begin
                        state_d = RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(rd_latency - 2);
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    mem_array_mips #(
        .width (mem_width),
        .depth (mem_depth),
        .idx_w (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (mem_we),
        .waddr_i (idx),
        .wdata_i (wdata_q),
        .raddr_i (idx),
        .rdata_o (rd_data)
    );

endmodule

// File: tb/tb_mem_responder_mips.sv
// Scoreboard bench for mem_responder_mips: dut0 uses rd_latency=2, dut1 uses rd_latency=1.
// Expectations follow MEM_ERR_CHECK_EN when the macro is defined for the build.
module tb_mem_responder_mips;

`ifdef MEM_ERR_CHECK_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];

    mem_responder_mips_if #(.mem_width(32), .addr_width(32)) bus0 ();
    mem_responder_mips_if #(.mem_width(32), .addr_width(32)) bus1 ();

    mem_responder_mips #(.mem_width(32), .addr_width(32), .mem_depth(64), .rd_latency(2))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    mem_responder_mips #(.mem_width(32), .addr_width(32), .mem_depth(64), .rd_latency(1))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    function automatic logic rdy(input int s);
        return (s == 0) ? bus0.req_ready : bus1.req_ready;
    endfunction

    function automatic int qsize(input int s);
        return (s == 0) ? q0.size() : q1.size();
    endfunction

    task automatic drive(input int s, input logic v, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd);
        if (s == 0) begin
            bus0.req_valid = v; bus0.req_wr = wr; bus0.req_addr = a; bus0.req_wdata = wd;
        end else begin
            bus1.req_valid = v; bus1.req_wr = wr; bus1.req_addr = a; bus1.req_wdata = wd;
        end
    endtask

    // Present a request, wait for acceptance, optionally record the expected response.
    task automatic issue(input int s, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] ed, input logic ee, input bit push, output int acc);
        int   k;
        exp_t x;
        @(negedge clk);
        drive(s, 1'b1, wr, a, wd);
        k = 0;
        while (!rdy(s) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!rdy(s)) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout dut%0d: req_ready stayed 0, required 1", s);
        end
        acc    = cyc + 1;
        x.data = ed;
        x.err  = ee;
        x.cyc  = cyc + ((s == 0) ? 2 : 1);
        if (push) begin
            if (s == 0) q0.push_back(x); else q1.push_back(x);
        end
        @(posedge clk);
        #1;
        drive(s, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic drain(input int s);
        int k = 0;
        while (qsize(s) != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (qsize(s) != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout dut%0d: %0d responses missing, required 0", s, qsize(s));
            if (s == 0) q0.delete(); else q1.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic mon(input int s, input logic v, input logic [31:0] d, input logic e);
        exp_t x;
        if (v) begin
            if (qsize(s) == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rsp dut%0d: got rsp_valid=1 data=%h, required no response", s, d);
            end else begin
                x = (s == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("rsp_rdata_dut%0d", s), 64'(d), 64'(x.data));
                chk($sformatf("rsp_err_dut%0d", s), 64'(e), 64'(x.err));
                chk($sformatf("rsp_cycle_dut%0d", s), 64'(cyc), 64'(x.cyc));
            end
        end else begin
            chk($sformatf("idle_rsp_zero_dut%0d", s), {31'h0, e, d}, 64'h0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus0.rsp_valid, bus0.rsp_rdata, bus0.rsp_err);
        mon(1, bus1.rsp_valid, bus1.rsp_rdata, bus1.rsp_err);
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, prev;
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk("rsp_valid_in_reset", 64'(bus0.rsp_valid), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("req_ready_after_reset_dut0", 64'(bus0.req_ready), 64'd1);
        chk("req_ready_after_reset_dut1", 64'(bus1.req_ready), 64'd1);
        chk("rsp_valid_after_reset_dut0", 64'(bus0.rsp_valid), 64'd0);

        // Misaligned store: faults when checked, otherwise lands on word 4.
        issue(0, 1'b1, 32'h12, 32'h1111_1111, 32'h0, ERR, 1'b1, acc);
        issue(0, 1'b0, 32'h10, 32'h0, ERR ? 32'h0 : 32'h1111_1111, 1'b0, 1'b1, acc);
        issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, acc);
        drain(0);

        // Load latency and ready shape around one transaction.
        issue(0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, acc);
        @(negedge clk);
        chk("ready_low_busy", 64'(bus0.req_ready), 64'd0);
        chk("no_rsp_busy", 64'(bus0.rsp_valid), 64'd0);
        @(negedge clk);
        chk("ready_low_resp", 64'(bus0.req_ready), 64'd0);
        chk("rsp_in_resp", 64'(bus0.rsp_valid), 64'd1);
        @(negedge clk);
        chk("ready_back_high", 64'(bus0.req_ready), 64'd1);
        chk("rsp_one_cycle", 64'(bus0.rsp_valid), 64'd0);
        drain(0);

        // Request held while busy with another address must be ignored.
        issue(0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, acc);
        drive(0, 1'b1, 1'b0, 32'h14, 32'h0);
        @(negedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drain(0);
        repeat (3) @(negedge clk);

        // Out-of-range address: faults when checked, otherwise wraps to word 0.
        issue(0, 1'b1, 32'h100, 32'hCAFE_F00D, 32'h0, ERR, 1'b1, acc);
        prev = acc;
        issue(0, 1'b0, 32'h0, 32'h0, ERR ? 32'h0 : 32'hCAFE_F00D, 1'b0, 1'b1, acc);
        chk("b2b_spacing_lat2", 64'(acc - prev), 64'd3);
        issue(0, 1'b0, 32'h100, 32'h0, ERR ? 32'h0 : 32'hCAFE_F00D, ERR, 1'b1, acc);
        drain(0);

        // Reset during BUSY of a store: no response and no write; array is cleared.
        issue(0, 1'b1, 32'h20, 32'h1234_5678, 32'h0, 1'b0, 1'b0, acc);
        #2;
        rst = 1'b0;
        #1;
        chk("ready_on_midop_reset", 64'(bus0.req_ready), 64'd1);
        chk("rsp_valid_on_midop_reset", 64'(bus0.rsp_valid), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        issue(0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b1, acc);
        issue(0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b1, acc);
        drain(0);

        // rd_latency=1: back-to-back stores then loads, one accept every 2 cycles.
        issue(1, 1'b1, 32'h4, 32'hA1A1_0001, 32'h0, 1'b0, 1'b1, acc);
        issue(1, 1'b1, 32'h8, 32'hB2B2_0002, 32'h0, 1'b0, 1'b1, acc);
        issue(1, 1'b1, 32'hC, 32'hC3C3_0003, 32'h0, 1'b0, 1'b1, acc);
        issue(1, 1'b0, 32'h4, 32'h0, 32'hA1A1_0001, 1'b0, 1'b1, acc);
        prev = acc;
        issue(1, 1'b0, 32'h8, 32'h0, 32'hB2B2_0002, 1'b0, 1'b1, acc);
        chk("b2b_spacing_lat1_a", 64'(acc - prev), 64'd2);
        prev = acc;
        issue(1, 1'b0, 32'hC, 32'h0, 32'hC3C3_0003, 1'b0, 1'b1, acc);
        chk("b2b_spacing_lat1_b", 64'(acc - prev), 64'd2);
        drain(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
